// File: rtl/mips_pkg.sv
// Purpose: shared constants for the fetch/decode slice of the MIPS pipeline.
// Latency: n/a (constants only).
// Backpressure: n/a.
package mips_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    localparam int RS_MSB = 25;
    localparam int RS_LSB = 21;
    localparam int RT_MSB = 20;
    localparam int RT_LSB = 16;

    localparam logic [31:0] PC_INC = 32'd4;

endpackage

// File: rtl/if_id_stage_if.sv
// Purpose: bundle of fetch-side, hazard and IF/ID signals around the if_id_stage.
// Latency: n/a (wiring only).
// Backpressure: stall_out is the hold request; br_taken overrides it.
interface if_id_stage_if #(
    parameter int CNT_W = 16
);
    logic [31:0]      instr_in;
    logic             br_taken;
    logic [31:0]      br_target;
    logic             id_ex_memread_in;
    logic [4:0]       id_ex_rt_in;
    logic [31:0]      pc_out;
    logic [31:0]      if_id_instr_out;
    logic [31:0]      if_id_pc_plus4_out;
    logic             if_id_valid_out;
    logic             stall_out;
    logic [CNT_W-1:0] stall_count_out;
    logic [CNT_W-1:0] flush_count_out;

    // Environment side: instruction memory, branch unit and ID/EX stage.
    modport master (
        output instr_in, br_taken, br_target, id_ex_memread_in, id_ex_rt_in,
        input  pc_out, if_id_instr_out, if_id_pc_plus4_out, if_id_valid_out,
        input  stall_out, stall_count_out, flush_count_out
    );

    // Stage side.
    modport slave (
        input  instr_in, br_taken, br_target, id_ex_memread_in, id_ex_rt_in,
        output pc_out, if_id_instr_out, if_id_pc_plus4_out, if_id_valid_out,
        output stall_out, stall_count_out, flush_count_out
    );
endinterface

// File: rtl/load_use_detect.sv
// Purpose: detect a load in ID/EX whose destination feeds the instruction in IF/ID.
// Latency: purely combinational.
// Backpressure: stall_out holds PC and IF/ID; never asserted for an invalid IF/ID entry.
module load_use_detect (
    input  logic       if_id_valid_out,
    input  logic [4:0] rs,
    input  logic [4:0] rt,
    input  logic       id_ex_memread_in,
    input  logic [4:0] id_ex_rt_in,
    output logic       stall_out
);

    // Register $0 never carries a real dependency, so a load into it never stalls.
    always_comb begin
        stall_out = 1'b0;
        if (if_id_valid_out && id_ex_memread_in && (id_ex_rt_in != 5'd0) &&
            ((id_ex_rt_in == rs) || (id_ex_rt_in == rt))) begin
            stall_out = 1'b1;
        end
    end

endmodule

// File: rtl/if_id_stage.sv
// Purpose: PC register, IF/ID pipeline register and stall/flush event counters.
// Latency: one clk edge from fetch address to IF/ID output.
// Backpressure: load-use stall holds PC and IF/ID; a taken branch flushes and wins over stall.
module if_id_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic         clk,
    input  logic         reset,
    if_id_stage_if.slave bus
);

    logic [31:0]      pc;
    logic [31:0]      pc_plus4;
    logic [31:0]      if_id_instr;
    logic [31:0]      if_id_pc_plus4;
    logic             if_id_valid;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic             stall;

    // Natural 32-bit wrap gives the modulo-2^32 PC arithmetic.
    assign pc_plus4 = pc + PC_INC;

    load_use_detect u_load_use_detect (
        .if_id_valid_out  (if_id_valid),
        .rs               (if_id_instr[RS_MSB:RS_LSB]),
        .rt               (if_id_instr[RT_MSB:RT_LSB]),
        .id_ex_memread_in (bus.id_ex_memread_in),
        .id_ex_rt_in      (bus.id_ex_rt_in),
        .stall_out        (stall)
    );

    // PC and IF/ID register: flush beats stall, stall holds, otherwise advance.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc             <= RESET_PC;
            if_id_instr    <= NOP_INSTR;
            if_id_pc_plus4 <= 32'h0;
            if_id_valid    <= 1'b0;
        end else if (bus.br_taken) begin
            pc             <= bus.br_target & ~32'h3;
            if_id_instr    <= NOP_INSTR;
            if_id_pc_plus4 <= 32'h0;
            if_id_valid    <= 1'b0;
        end else if (!stall) begin
            pc             <= pc_plus4;
            if_id_instr    <= bus.instr_in;
            if_id_pc_plus4 <= pc_plus4;
            if_id_valid    <= 1'b1;
        end
    end

    // Saturating event counters; a stall masked by a flush is not counted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (bus.br_taken) begin
                if (flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
            end else if (stall) begin
                if (stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end

    assign bus.pc_out             = pc;
    assign bus.if_id_instr_out    = if_id_instr;
    assign bus.if_id_pc_plus4_out = if_id_pc_plus4;
    assign bus.if_id_valid_out    = if_id_valid;
    assign bus.stall_out          = stall;
    assign bus.stall_count_out    = stall_cnt;
    assign bus.flush_count_out    = flush_cnt;

endmodule

// File: tb/tb_if_id_stage.sv
// Purpose: directed self-checking bench for if_id_stage.
// Latency: checks sampled on the falling edge, one rising edge after each stimulus step.
// Backpressure: exercises stall, flush, stall+flush overlap and counter saturation.
module tb_if_id_stage;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    if_id_stage_if #(.CNT_W(16)) bus ();

    if_id_stage #(
        .RESET_PC (32'h0000_0000),
        .CNT_W    (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Small instruction memory addressed combinationally by pc_out.
    function automatic logic [31:0] imem(input logic [31:0] addr);
        case (addr)
            32'h0000_0000: imem = 32'h8C08_0004;  // lw  $8, 4($0)
            32'h0000_0004: imem = 32'h0109_5020;  // add $10, $8, $9
            32'h0000_0008: imem = 32'h012A_5820;  // add $11, $9, $10
            default:       imem = 32'h0000_0020;  // add $0, $0, $0
        endcase
    endfunction

    assign bus.instr_in = imem(bus.pc_out);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset                = 1'b1;
        bus.br_taken         = 1'b0;
        bus.br_target        = 32'h0;
        bus.id_ex_memread_in = 1'b0;
        bus.id_ex_rt_in      = 5'd0;

        // Reset state
        #2;
        check("rst_pc",    bus.pc_out, 32'h0);
        check("rst_instr", bus.if_id_instr_out, 32'h0);
        check("rst_pc4",   bus.if_id_pc_plus4_out, 32'h0);
        check("rst_valid", {31'h0, bus.if_id_valid_out}, 32'h0);
        check("rst_stall", {31'h0, bus.stall_out}, 32'h0);
        check("rst_scnt",  {16'h0, bus.stall_count_out}, 32'h0);
        check("rst_fcnt",  {16'h0, bus.flush_count_out}, 32'h0);

        // First fetch after release
        @(negedge clk);
        reset = 1'b0;
        tick();
        check("f0_instr", bus.if_id_instr_out, 32'h8C08_0004);
        check("f0_pc4",   bus.if_id_pc_plus4_out, 32'h4);
        check("f0_pc",    bus.pc_out, 32'h4);
        check("f0_valid", {31'h0, bus.if_id_valid_out}, 32'h1);

        // Advance to the add that reads $8/$9
        tick();
        check("f1_instr", bus.if_id_instr_out, 32'h0109_5020);
        check("f1_pc",    bus.pc_out, 32'h8);
        check("f1_pc4",   bus.if_id_pc_plus4_out, 32'h8);

        // Load-use on rt=9: stall for one edge
        bus.id_ex_memread_in = 1'b1;
        bus.id_ex_rt_in      = 5'd9;
        #1;
        check("lu_stall", {31'h0, bus.stall_out}, 32'h1);
        tick();
        check("lu_pc",    bus.pc_out, 32'h8);
        check("lu_instr", bus.if_id_instr_out, 32'h0109_5020);
        check("lu_pc4",   bus.if_id_pc_plus4_out, 32'h8);
        check("lu_scnt",  {16'h0, bus.stall_count_out}, 32'h1);

        // Load into $0 never stalls
        bus.id_ex_rt_in = 5'd0;
        #1;
        check("r0_stall", {31'h0, bus.stall_out}, 32'h0);
        tick();
        check("r0_instr", bus.if_id_instr_out, 32'h012A_5820);
        check("r0_pc",    bus.pc_out, 32'hC);
        check("r0_scnt",  {16'h0, bus.stall_count_out}, 32'h1);

        // Stall and branch together: flush wins, no stall counted
        bus.id_ex_rt_in = 5'd10;
        bus.br_taken    = 1'b1;
        bus.br_target   = 32'h40;
        #1;
        check("sb_stall", {31'h0, bus.stall_out}, 32'h1);
        tick();
        check("sb_pc",    bus.pc_out, 32'h40);
        check("sb_instr", bus.if_id_instr_out, 32'h0);
        check("sb_pc4",   bus.if_id_pc_plus4_out, 32'h0);
        check("sb_valid", {31'h0, bus.if_id_valid_out}, 32'h0);
        check("sb_fcnt",  {16'h0, bus.flush_count_out}, 32'h1);
        check("sb_scnt",  {16'h0, bus.stall_count_out}, 32'h1);

        // Invalid IF/ID never stalls
        bus.id_ex_rt_in = 5'd0;
        check("inv_stall", {31'h0, bus.stall_out}, 32'h0);

        // Unaligned target is forced to word alignment
        bus.id_ex_memread_in = 1'b0;
        bus.br_target        = 32'h43;
        tick();
        check("al_pc",   bus.pc_out, 32'h40);
        check("al_fcnt", {16'h0, bus.flush_count_out}, 32'h2);

        // PC wrap from the top of the address space
        bus.br_target = 32'hFFFF_FFFC;
        tick();
        check("wr_pc0", bus.pc_out, 32'hFFFF_FFFC);
        bus.br_taken = 1'b0;
        tick();
        check("wr_pc",    bus.pc_out, 32'h0);
        check("wr_pc4",   bus.if_id_pc_plus4_out, 32'h0);
        check("wr_instr", bus.if_id_instr_out, 32'h0000_0020);
        check("wr_valid", {31'h0, bus.if_id_valid_out}, 32'h1);
        check("wr_fcnt",  {16'h0, bus.flush_count_out}, 32'h3);

        // Refill to the dependent add, then hold the stall long enough to saturate
        tick();
        tick();
        check("rf_instr", bus.if_id_instr_out, 32'h0109_5020);
        bus.id_ex_memread_in = 1'b1;
        bus.id_ex_rt_in      = 5'd9;
        for (int i = 0; i < 70000; i++) begin
            tick();
        end
        check("sat_scnt",  {16'h0, bus.stall_count_out}, 32'h0000_FFFF);
        check("sat_pc",    bus.pc_out, 32'h8);
        check("sat_instr", bus.if_id_instr_out, 32'h0109_5020);
        check("sat_stall", {31'h0, bus.stall_out}, 32'h1);

        // Reset mid-stall takes effect without a clock edge
        #1;
        reset = 1'b1;
        #1;
        check("mr_pc",    bus.pc_out, 32'h0);
        check("mr_instr", bus.if_id_instr_out, 32'h0);
        check("mr_pc4",   bus.if_id_pc_plus4_out, 32'h0);
        check("mr_valid", {31'h0, bus.if_id_valid_out}, 32'h0);
        check("mr_stall", {31'h0, bus.stall_out}, 32'h0);
        check("mr_scnt",  {16'h0, bus.stall_count_out}, 32'h0);
        check("mr_fcnt",  {16'h0, bus.flush_count_out}, 32'h0);

        // No residual stall after release; ID/EX inputs still present
        @(negedge clk);
        reset = 1'b0;
        tick();
        check("pr_instr", bus.if_id_instr_out, 32'h8C08_0004);
        check("pr_pc",    bus.pc_out, 32'h4);
        check("pr_stall", {31'h0, bus.stall_out}, 32'h0);
        check("pr_scnt",  {16'h0, bus.stall_count_out}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
